// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command framer: FSM states,
// opcode limits and the frame-length derivation.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam logic [7:0] OPCODE_MAX_DEFAULT = 8'h0F;

    // Opcode byte + payload + optional trailing checksum byte.
    function automatic int frame_len(input int payload_bytes, input int checksum_en);
        return 1 + payload_bytes + checksum_en;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always presented on head_data
// (zero while empty) and a push into a full FIFO is accepted when popping.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || pop);
    assign head_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/spi_cmd_framer.sv
// Assembles indexed SPI bytes into command frames, validates sequence, checksum,
// opcode and inter-byte timeout, and queues good frames for the consumer.
module spi_cmd_framer
    import spi_cmd_pkg::*;
#(
    parameter int         PAYLOAD_BYTES  = 8,
    parameter int         CHECKSUM_EN    = 1,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] OPCODE_MAX     = OPCODE_MAX_DEFAULT,
    parameter int         FRAME_IDX_W    = 4
) (
    input  logic                       sysClk,
    input  logic                       rst_n,
    input  logic [7:0]                 spi_byte,
    input  logic                       spi_input_valid,
    input  logic [FRAME_IDX_W-1:0]     spi_byte_num,
    output logic [7:0]                 cmd_opcode,
    output logic [8*PAYLOAD_BYTES-1:0] cmd_payload,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       err_seq,
    output logic                       err_checksum,
    output logic                       err_opcode,
    output logic                       err_timeout,
    output logic                       err_overflow,
    output logic [7:0]                 frames_dropped,
    output logic                       busy
);
    localparam int FRAME_LEN = frame_len(PAYLOAD_BYTES, CHECKSUM_EN);
    localparam int ENTRY_W   = 8 + 8 * PAYLOAD_BYTES;
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FRAME_IDX_W-1:0] LAST_IDX = FRAME_IDX_W'(FRAME_LEN - 1);
    localparam logic [FRAME_IDX_W-1:0] IDX_ONE  = FRAME_IDX_W'(1);
    localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                     state_q;
    logic [FRAME_IDX_W-1:0]     exp_idx_q;
    logic [7:0]                 xor_q;
    logic [7:0]                 opcode_q;
    logic [7:0]                 drop_q;
    logic [TMO_W-1:0]           tmo_q;
    logic                       err_seq_q, err_checksum_q, err_opcode_q, err_timeout_q, err_overflow_q;
    logic [8*PAYLOAD_BYTES-1:0] payload_d;

    logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [ENTRY_W-1:0] head;
    logic               start_byte, in_order, ck_bad, op_bad, ovf, frame_bad, tmo_hit, drop_inc;

    always_comb begin
        start_byte = spi_input_valid && (spi_byte_num == '0);
        in_order   = (state_q == ST_COLLECT) && spi_input_valid && (spi_byte_num == exp_idx_q);
        ck_bad     = (CHECKSUM_EN != 0) && (xor_q != 8'h00);
        op_bad     = opcode_q > OPCODE_MAX;
        ovf        = fifo_full && !fifo_pop;
        frame_bad  = (state_q == ST_CHECK) && (ck_bad || op_bad || ovf);
        fifo_push  = (state_q == ST_CHECK) && !(ck_bad || op_bad || ovf);
        tmo_hit    = (state_q == ST_COLLECT) && !spi_input_valid && (tmo_q == TMO_LAST);
        drop_inc   = ((state_q == ST_COLLECT) && spi_input_valid && !in_order) || tmo_hit || frame_bad;
    end

    // One register lane per payload byte; index 1 lands in the most significant lane.
    for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_lane
        logic [7:0] lane_q;
        always_ff @(posedge sysClk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else if (in_order && (spi_byte_num == FRAME_IDX_W'(gi + 1))) begin
                lane_q <= spi_byte;
            end
        end
        assign payload_d[8*(PAYLOAD_BYTES-1-gi) +: 8] = lane_q;
    end

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            exp_idx_q      <= '0;
            xor_q          <= '0;
            opcode_q       <= '0;
            drop_q         <= '0;
            tmo_q          <= '0;
            err_seq_q      <= 1'b0;
            err_checksum_q <= 1'b0;
            err_opcode_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            err_seq_q      <= 1'b0;
            err_checksum_q <= 1'b0;
            err_opcode_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            if (drop_inc && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

            case (state_q)
                ST_COLLECT: begin
                    if (spi_input_valid) begin
                        tmo_q <= '0;
                        if (in_order) begin
                            xor_q     <= xor_q ^ spi_byte;
                            exp_idx_q <= exp_idx_q + IDX_ONE;
                            if (spi_byte_num == LAST_IDX) state_q <= ST_CHECK;
                        end else if (spi_byte_num == '0) begin
                            err_seq_q <= 1'b1;
                            opcode_q  <= spi_byte;
                            xor_q     <= spi_byte;
                            exp_idx_q <= IDX_ONE;
                        end else begin
                            err_seq_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    if (state_q == ST_CHECK) begin
                        err_checksum_q <= ck_bad;
                        err_opcode_q   <= !ck_bad && op_bad;
                        err_overflow_q <= !ck_bad && !op_bad && ovf;
                    end
                    if (start_byte) begin
                        opcode_q  <= spi_byte;
                        xor_q     <= spi_byte;
                        exp_idx_q <= IDX_ONE;
                        tmo_q     <= '0;
                        state_q   <= ST_COLLECT;
                    end else begin
                        state_q <= ST_IDLE;
                        // A frame verdict pulse wins over a stray byte's sequence pulse.
                        if (spi_input_valid && !frame_bad) err_seq_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign fifo_pop = !fifo_empty && cmd_ready;

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sysClk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({opcode_q, payload_d}),
        .pop       (fifo_pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_valid      = !fifo_empty;
    assign cmd_opcode     = head[ENTRY_W-1 -: 8];
    assign cmd_payload    = head[8*PAYLOAD_BYTES-1:0];
    assign err_seq        = err_seq_q;
    assign err_checksum   = err_checksum_q;
    assign err_opcode     = err_opcode_q;
    assign err_timeout    = err_timeout_q;
    assign err_overflow   = err_overflow_q;
    assign frames_dropped = drop_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Bench for spi_cmd_framer: two configurations checked every cycle against a
// frame-level reference model, plus directed scenarios with literal expectations.
module tb_spi_cmd_framer;
    localparam int PB_A = 8, CK_A = 1, DP_A = 4, TO_A = 16;
    localparam int PB_B = 2, CK_B = 0, DP_B = 2, TO_B = 8;
    localparam logic [7:0] OPMAX = 8'h0F;

    logic       sysClk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       v   [2];
    logic [3:0] ix  [2];
    logic [7:0] bt  [2];
    logic       rdy [2];

    logic [7:0]  a_op, a_drop, b_op, b_drop;
    logic [63:0] a_pl;
    logic [15:0] b_pl;
    logic a_valid, a_es, a_ec, a_eo, a_et, a_ev, a_busy;
    logic b_valid, b_es, b_ec, b_eo, b_et, b_ev, b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sysClk = ~sysClk;

    spi_cmd_framer #(.PAYLOAD_BYTES(PB_A), .CHECKSUM_EN(CK_A), .FIFO_DEPTH(DP_A),
                     .TIMEOUT_CYCLES(TO_A), .OPCODE_MAX(OPMAX), .FRAME_IDX_W(4)) dut_a (
        .sysClk(sysClk), .rst_n(rst_n), .spi_byte(bt[0]), .spi_input_valid(v[0]),
        .spi_byte_num(ix[0]), .cmd_opcode(a_op), .cmd_payload(a_pl), .cmd_valid(a_valid),
        .cmd_ready(rdy[0]), .err_seq(a_es), .err_checksum(a_ec), .err_opcode(a_eo),
        .err_timeout(a_et), .err_overflow(a_ev), .frames_dropped(a_drop), .busy(a_busy));

    spi_cmd_framer #(.PAYLOAD_BYTES(PB_B), .CHECKSUM_EN(CK_B), .FIFO_DEPTH(DP_B),
                     .TIMEOUT_CYCLES(TO_B), .OPCODE_MAX(OPMAX), .FRAME_IDX_W(4)) dut_b (
        .sysClk(sysClk), .rst_n(rst_n), .spi_byte(bt[1]), .spi_input_valid(v[1]),
        .spi_byte_num(ix[1]), .cmd_opcode(b_op), .cmd_payload(b_pl), .cmd_valid(b_valid),
        .cmd_ready(rdy[1]), .err_seq(b_es), .err_checksum(b_ec), .err_opcode(b_eo),
        .err_timeout(b_et), .err_overflow(b_ev), .frames_dropped(b_drop), .busy(b_busy));

    function automatic int pb(input int d); return (d == 0) ? PB_A : PB_B; endfunction
    function automatic int ck(input int d); return (d == 0) ? CK_A : CK_B; endfunction
    function automatic int dp(input int d); return (d == 0) ? DP_A : DP_B; endfunction
    function automatic int tmo(input int d); return (d == 0) ? TO_A : TO_B; endfunction
    function automatic int flen(input int d); return 1 + pb(d) + ck(d); endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: frames as byte queues, command queue as a plain queue.
    logic [7:0]  m_fb   [2][$];
    logic [7:0]  m_pf   [2][$];
    logic [71:0] m_fifo [2][$];
    bit          m_act  [2];
    bit          m_pend [2];
    int          m_idle [2];
    int          m_drop [2];
    bit   [4:0]  m_err  [2];   // {seq, checksum, opcode, overflow, timeout}

    task automatic model_reset(input int d);
        m_fb[d].delete(); m_pf[d].delete(); m_fifo[d].delete();
        m_act[d] = 0; m_pend[d] = 0; m_idle[d] = 0; m_drop[d] = 0; m_err[d] = '0;
    endtask

    task automatic drop_one(input int d);
        if (m_drop[d] < 255) m_drop[d]++;
    endtask

    task automatic model_step(input int d);
        bit          pop, push, frame_err;
        logic [7:0]  x;
        logic [63:0] pl;
        pop = (m_fifo[d].size() > 0) && rdy[d];
        push = 0; frame_err = 0; m_err[d] = '0; pl = '0; x = '0;
        if (m_pend[d]) begin
            for (int i = 0; i < m_pf[d].size(); i++) x ^= m_pf[d][i];
            if (ck(d) != 0 && x != 8'h00)                   m_err[d][3] = 1;
            else if (m_pf[d][0] > OPMAX)                    m_err[d][2] = 1;
            else if (m_fifo[d].size() == dp(d) && !pop)     m_err[d][1] = 1;
            else push = 1;
            frame_err = !push;
            if (frame_err) drop_one(d);
            for (int i = 1; i <= pb(d); i++) pl = {pl[55:0], m_pf[d][i]};
            m_pend[d] = 0;
        end
        if (pop) void'(m_fifo[d].pop_front());
        if (push) m_fifo[d].push_back({m_pf[d][0], pl});
        if (m_act[d]) begin
            if (v[d]) begin
                m_idle[d] = 0;
                if (int'(ix[d]) == m_fb[d].size()) begin
                    m_fb[d].push_back(bt[d]);
                    if (m_fb[d].size() == flen(d)) begin
                        m_pf[d] = m_fb[d]; m_pend[d] = 1; m_act[d] = 0; m_fb[d].delete();
                    end
                end else if (ix[d] == 4'd0) begin
                    m_err[d][4] = 1; drop_one(d);
                    m_fb[d].delete(); m_fb[d].push_back(bt[d]);
                end else begin
                    m_err[d][4] = 1; drop_one(d); m_act[d] = 0; m_fb[d].delete();
                end
            end else begin
                m_idle[d]++;
                if (m_idle[d] == tmo(d)) begin
                    m_err[d][0] = 1; drop_one(d); m_act[d] = 0; m_fb[d].delete();
                end
            end
        end else if (v[d]) begin
            if (ix[d] == 4'd0) begin
                m_act[d] = 1; m_idle[d] = 0; m_fb[d].delete(); m_fb[d].push_back(bt[d]);
            end else if (!frame_err) begin
                m_err[d][4] = 1;
            end
        end
    endtask

    always @(posedge sysClk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            else        model_step(d);
        end
    end

    task automatic check_dut(input int d, input logic vld, input logic [7:0] op, input logic [63:0] pl,
                             input logic [4:0] errs, input logic [7:0] drop, input logic bsy);
        logic [71:0] head;
        head = (m_fifo[d].size() > 0) ? m_fifo[d][0] : 72'h0;
        chk($sformatf("dut%0d cmd_valid", d), 64'(vld), 64'(m_fifo[d].size() > 0));
        chk($sformatf("dut%0d cmd_opcode", d), 64'(op), 64'(head[71:64]));
        chk($sformatf("dut%0d cmd_payload", d), pl, head[63:0]);
        chk($sformatf("dut%0d err{seq,ck,op,ovf,tmo}", d), 64'(errs), 64'(m_err[d]));
        chk($sformatf("dut%0d frames_dropped", d), 64'(drop), 64'(m_drop[d]));
        chk($sformatf("dut%0d busy", d), 64'(bsy), 64'(m_act[d] || m_pend[d]));
    endtask

    always @(negedge sysClk) begin
        check_dut(0, a_valid, a_op, a_pl, {a_es, a_ec, a_eo, a_ev, a_et}, a_drop, a_busy);
        check_dut(1, b_valid, b_op, {48'h0, b_pl}, {b_es, b_ec, b_eo, b_ev, b_et}, b_drop, b_busy);
    end

    task automatic drive(input int d, input logic vv, input logic [3:0] ii, input logic [7:0] bb);
        v[d] = vv; ix[d] = ii; bt[d] = bb;
        @(posedge sysClk); #1;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic send_frame(input int d, input logic [7:0] op, input logic [63:0] pl, input bit bad_ck);
        logic [7:0] x, by;
        x = op;
        drive(d, 1'b1, 4'd0, op);
        for (int i = 1; i <= pb(d); i++) begin
            by = pl[8*(pb(d)-i) +: 8];
            x ^= by;
            drive(d, 1'b1, 4'(i), by);
        end
        if (ck(d) != 0) drive(d, 1'b1, 4'(pb(d) + 1), bad_ck ? (x ^ 8'h01) : x);
        v[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n, gp[2], gap[2], rbias, r;
        logic [7:0] gx[2];
        for (int d = 0; d < 2; d++) begin
            v[d] = 0; ix[d] = 0; bt[d] = 0; rdy[d] = 0; gp[d] = 0; gap[d] = 0; gx[d] = 0;
        end
        repeat (3) @(posedge sysClk);
        #1 rst_n = 1'b1;
        idle(0);
        chk("reset cmd_valid", 64'(a_valid), 64'd0);
        chk("reset frames_dropped", 64'(a_drop), 64'd0);
        chk("reset busy", 64'(a_busy), 64'd0);

        // Good frame: cmd_valid two cycles after the last byte.
        send_frame(0, 8'h08, 64'h0, 0);
        chk("good valid in CHECK", 64'(a_valid), 64'd0);
        idle(0);
        chk("good cmd_valid", 64'(a_valid), 64'd1);
        chk("good cmd_opcode", 64'(a_op), 64'h08);
        chk("good cmd_payload", a_pl, 64'h0);
        rdy[0] = 1; idle(0); rdy[0] = 0;
        chk("good popped", 64'(a_valid), 64'd0);

        send_frame(0, 8'h08, 64'h0, 1);
        idle(0);
        chk("bad ck err_checksum", 64'(a_ec), 64'd1);
        chk("bad ck dropped", 64'(a_drop), 64'd1);
        chk("bad ck cmd_valid", 64'(a_valid), 64'd0);
        send_frame(0, 8'h20, 64'h0, 0);
        idle(0);
        chk("bad op err_opcode", 64'(a_eo), 64'd1);
        chk("bad op dropped", 64'(a_drop), 64'd2);

        drive(0, 1, 4'd0, 8'h03); drive(0, 1, 4'd1, 8'h00); drive(0, 1, 4'd3, 8'h00);
        chk("seq gap err_seq", 64'(a_es), 64'd1);
        chk("seq gap busy", 64'(a_busy), 64'd0);
        chk("seq gap dropped", 64'(a_drop), 64'd3);
        idle(0);

        drive(0, 1, 4'd0, 8'h03); drive(0, 1, 4'd1, 8'h00); drive(0, 1, 4'd0, 8'h05);
        chk("restart err_seq", 64'(a_es), 64'd1);
        chk("restart dropped", 64'(a_drop), 64'd4);
        for (int i = 1; i <= 8; i++) drive(0, 1, 4'(i), 8'h00);
        drive(0, 1, 4'd9, 8'h05);
        idle(0);
        chk("restart cmd_opcode", 64'(a_op), 64'h05);
        chk("restart cmd_valid", 64'(a_valid), 64'd1);
        rdy[0] = 1; idle(0); rdy[0] = 0;

        drive(0, 1, 4'd0, 8'h02); drive(0, 1, 4'd1, 8'h11);
        n = 0;
        do begin idle(0); n++; end while (!a_et && n < 40);
        chk("timeout idle cycles", 64'(n), 64'd16);
        chk("timeout busy", 64'(a_busy), 64'd0);
        chk("timeout dropped", 64'(a_drop), 64'd5);
        send_frame(0, 8'h07, 64'h1112131415161718, 0);
        idle(0);
        chk("after tmo opcode", 64'(a_op), 64'h07);
        chk("after tmo payload", a_pl, 64'h1112131415161718);
        rdy[0] = 1; idle(0); rdy[0] = 0;

        for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 64'h0, 0);
        idle(0);
        chk("overflow err_overflow", 64'(a_ev), 64'd1);
        chk("overflow dropped", 64'(a_drop), 64'd6);
        rdy[0] = 1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain order %0d", k), 64'(a_op), 64'(k));
            idle(0);
        end
        chk("drain empty", 64'(a_valid), 64'd0);
        rdy[0] = 0;

        send_frame(0, 8'h01, 64'h0, 0);
        send_frame(0, 8'h02, 64'h0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 4'(i), 8'h09);
        v[0] = 0;
        chk("pre-reset queued", 64'(a_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("mid reset cmd_valid", 64'(a_valid), 64'd0);
        chk("mid reset cmd_opcode", 64'(a_op), 64'd0);
        chk("mid reset cmd_payload", a_pl, 64'd0);
        chk("mid reset dropped", 64'(a_drop), 64'd0);
        chk("mid reset busy", 64'(a_busy), 64'd0);
        @(posedge sysClk); #1 rst_n = 1'b1;
        idle(0);

        send_frame(1, 8'h03, 64'hAA55, 0);
        idle(1);
        chk("nock cmd_valid", 64'(b_valid), 64'd1);
        chk("nock cmd_opcode", 64'(b_op), 64'h03);
        chk("nock cmd_payload", 64'(b_pl), 64'hAA55);
        rdy[1] = 1; idle(1); rdy[1] = 0;

        // Randomized traffic: mostly well-formed frames with injected faults.
        rbias = 60;
        for (int cyc = 0; cyc < 6000 && n_bad < 100; cyc++) begin
            if (cyc % 500 == 0) rbias = int'($urandom_range(5, 95));
            for (int d = 0; d < 2; d++) begin
                rdy[d] = ($urandom_range(0, 99) < rbias);
                r = int'($urandom_range(0, 999));
                if (gap[d] > 0) begin
                    gap[d]--; v[d] = 0;
                end else if (r < 6) begin
                    gap[d] = tmo(d) + int'($urandom_range(0, 3)) - 2; v[d] = 0;
                end else if (r < 100) begin
                    v[d] = 0;
                end else if (r < 130) begin
                    v[d] = 1; ix[d] = 4'($urandom_range(0, 15)); bt[d] = 8'($urandom);
                    gp[d] = (ix[d] == 0) ? 1 : 0; gx[d] = bt[d];
                end else begin
                    v[d] = 1; ix[d] = 4'(gp[d]);
                    if (gp[d] == 0) bt[d] = 8'($urandom_range(0, 18));
                    else if (ck(d) != 0 && gp[d] == flen(d) - 1)
                        bt[d] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : gx[d];
                    else bt[d] = 8'($urandom);
                    gx[d] = (gp[d] == 0) ? bt[d] : (gx[d] ^ bt[d]);
                    gp[d] = (gp[d] + 1 == flen(d)) ? 0 : gp[d] + 1;
                end
            end
            @(posedge sysClk); #1;
        end
        v[0] = 0; v[1] = 0;
        repeat (3) @(posedge sysClk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
